main_control_fsm: RTL and testbench
===================================

# main_control_fsm

Multicycle main control unit for the MIPS datapath. It decodes the 6-bit instruction opcode and sequences one instruction over 3–5 states. Each cycle it drives the datapath enables, the mux selects and the 2-bit `alu_op` that the ALU control decoder expands, together with `func`, into the 4-bit ALU operation. It sits between the instruction register's opcode field and every control input of the datapath.

## Interface
Parameters:
- `OP_W`, default 6: opcode width.

Ports (reset is asynchronous, active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `op`  in  6  opcode field of IR, stable from DECODE to end of instruction.
- `mem_ready`  in  1  memory access complete; used only with `MEM_WAIT_EN`.
- `pc_write`, `pc_write_cond`, `iord`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a`  out  1 each  datapath controls.
- `alu_src_b`, `pc_src`, `alu_op`  out  2 each  mux selects / ALU class (`alu_op`: 00 add, 01 sub, 10 use func).
- `instr_done`  out  1  one-cycle pulse in final state of each instruction.
- `illegal_op`  out  1  one-cycle pulse in DECODE on an unsupported opcode.
- `state`  out  4  current state encoding, for debug.

## Operation
- Opcodes: R-type 0x00, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02, ADDI 0x08. Any other opcode is illegal.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12–15 are unreachable; if entered, the next state is FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE by opcode: LW/SW→MEMADR, R→EXECUTE, BEQ→BRANCH, J→JUMP, ADDI→ADDIEX, illegal→FETCH.
  - MEMADR: LW→MEMRD, SW→MEMWR.
  - MEMRD→MEMWB. EXECUTE→ALUWB. ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP→FETCH.
- Outputs are Moore decodes of `state`. Every signal not listed for a state is 0.
  - FETCH: `mem_read`=1, `ir_write`=1, `alu_src_b`=01, `alu_op`=00, `pc_write`=1, `pc_src`=00.
  - DECODE: `alu_src_b`=11, `alu_op`=00 (branch target precompute).
  - MEMADR and ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - MEMRD: `mem_read`=1, `iord`=1.
  - MEMWR: `mem_write`=1, `iord`=1.
  - MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
  - EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
  - ALUWB: `reg_write`=1, `reg_dst`=1.
  - ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0.
  - BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_write_cond`=1, `pc_src`=01.
  - JUMP: `pc_write`=1, `pc_src`=10.
- `instr_done`=1 in MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP.

## Timing
- Reset: `state` is FETCH immediately and asynchronously, including mid-instruction. Outputs show FETCH values during and after reset. The datapath is held in reset alongside this block, so those values have no effect.
- Cycles per instruction, zero wait: BEQ 3, J 3, R 4, SW 4, ADDI 4, LW 5. Illegal: 2 (FETCH, DECODE).
- `op` is sampled only at the DECODE→next and MEMADR→next edges.
- `illegal_op` is high for exactly the DECODE cycle of an illegal opcode.

## Configuration
- `MAIN_CTRL_MEM_WAIT_EN` defined:
  - FETCH, MEMRD and MEMWR hold while `mem_ready`=0.
  - In FETCH, `pc_write` and `ir_write` are qualified by `mem_ready`; these are the only Mealy terms.
  - In MEMWR, `instr_done` is qualified by `mem_ready`.
  - Holding a state repeats its outputs.
- Undefined: `mem_ready` is ignored and every state lasts one cycle.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - the opcode constants;
  - the state enum (4-bit);
  - the `alu_op` constants ALU_ADD=00, ALU_SUB=01, ALU_FUNC=10, which the ALU control decoder also uses.
- No sub-module: the state register, next-state logic and output decode live in one module.

## Test plan
- Reset asserted mid-EXECUTE → `state`=0 within the same cycle, with no `reg_write` pulse.
- `op`=0x23, zero wait → states 0,1,2,3,4. `reg_write`=1 and `mem_to_reg`=1 only in cycle 5; `instr_done` only in cycle 5.
- `op`=0x00 → `alu_op`=10 in EXECUTE, `reg_dst`=1 in ALUWB, back to FETCH after 4 cycles.
- `op`=0x04 → BRANCH drives `pc_write_cond`=1, `pc_src`=01, `alu_op`=01. `op`=0x02 → JUMP drives `pc_write`=1, `pc_src`=10.
- `op`=0x3F → `illegal_op` pulses in DECODE, FETCH follows, and no write enable asserts.
- With `MAIN_CTRL_MEM_WAIT_EN`, SW with `mem_ready` low for 3 cycles in MEMWR → `mem_write` high for 4 cycles, `instr_done` on the 4th, then FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: opcodes, main FSM state encoding and the
// alu_op classes that the ALU control decoder expands together with func.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    function automatic logic is_legal_op(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
               (opcode == OP_BEQ)   || (opcode == OP_J)  || (opcode == OP_ADDI);
    endfunction

endpackage

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control FSM: decodes the opcode and sequences the datapath.
// Optional MAIN_CTRL_MEM_WAIT_EN stalls FETCH/MEMRD/MEMWR until mem_ready.
module main_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            mem_to_reg,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      pc_src,
    output logic [1:0]      alu_op,
    output logic            instr_done,
    output logic            illegal_op,
    output logic [3:0]      state
);

    state_t     cur_state;
    state_t     next_state;
    logic [5:0] opcode;
    logic       mem_ok;

    assign opcode = 6'(op);
    assign state  = cur_state;

`ifdef MAIN_CTRL_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_state <= S_FETCH;
        else        cur_state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (cur_state)
            S_FETCH:   next_state = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) next_state = S_MEMADR;
                else if (opcode == OP_RTYPE)            next_state = S_EXECUTE;
                else if (opcode == OP_BEQ)              next_state = S_BRANCH;
                else if (opcode == OP_J)                next_state = S_JUMP;
                else if (opcode == OP_ADDI)             next_state = S_ADDIEX;
                else                                    next_state = S_FETCH;
            end
            S_MEMADR:  next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   next_state = mem_ok ? S_MEMWB : S_MEMRD;
            S_MEMWR:   next_state = mem_ok ? S_FETCH : S_MEMWR;
            S_EXECUTE: next_state = S_ALUWB;
            S_ADDIEX:  next_state = S_ADDIWB;
            default:   next_state = S_FETCH;
        endcase
    end

    // Moore decode; mem_ok only gates the FETCH writes and the MEMWR done pulse
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        alu_op        = ALU_ADD;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_ok;
                pc_write  = mem_ok;
                alu_src_b = 2'b01;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = !is_legal_op(opcode);
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ok;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNC;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed testbench for main_control_fsm: per-state control words are hand-written
// constants; the mem_ready stall test runs only when MAIN_CTRL_MEM_WAIT_EN is defined.
module tb_main_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    int checkCount = 0;
    int errorCount = 0;

    main_control_fsm #(.OP_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_op(alu_op), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
    //  reg_dst, reg_write, alu_src_a, alu_src_b, pc_src, alu_op, instr_done, illegal_op}
    function automatic logic [17:0] ctrlWord();
        return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, pc_src, alu_op, instr_done, illegal_op};
    endfunction

    function automatic logic [17:0] expectedCtrl(input int s);
        case (s)
            0:  return 18'b100101000001000000;
            1:  return 18'b000000000011000000;
            2:  return 18'b000000000110000000;
            3:  return 18'b001100000000000000;
            4:  return 18'b000000101000000010;
            5:  return 18'b001010000000000010;
            6:  return 18'b000000000100001000;
            7:  return 18'b000000011000000010;
            8:  return 18'b010000000100010110;
            9:  return 18'b000000000110000000;
            10: return 18'b000000001000000010;
            11: return 18'b100000000000100010;
            default: return 18'h3FFFF;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Runs one instruction from FETCH, checking state and control word each cycle.
    task automatic applyStimulus(input string name, input logic [5:0] opcode,
                                 input int seq[], input bit illegal);
        logic [17:0] exp;
        op = opcode;
        for (int i = 0; i < seq.size(); i++) begin
            exp = expectedCtrl(seq[i]);
            if (illegal && seq[i] == 1) exp[0] = 1'b1;
            checkOutput($sformatf("%s state c%0d", name, i + 1), 32'(state), 32'(seq[i]));
            checkOutput($sformatf("%s ctrl c%0d", name, i + 1), 32'(ctrlWord()), 32'(exp));
            @(negedge clk);
        end
        checkOutput($sformatf("%s returns to FETCH", name), 32'(state), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        op        = 6'h00;
        mem_ready = 1'b1;
        #12;
        checkOutput("reset state", 32'(state), 32'd0);
        checkOutput("reset ctrl", 32'(ctrlWord()), 32'(expectedCtrl(0)));
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("LW",   6'h23, '{0, 1, 2, 3, 4}, 1'b0);
        applyStimulus("SW",   6'h2B, '{0, 1, 2, 5}, 1'b0);
        applyStimulus("R",    6'h00, '{0, 1, 6, 7}, 1'b0);
        applyStimulus("BEQ",  6'h04, '{0, 1, 8}, 1'b0);
        applyStimulus("J",    6'h02, '{0, 1, 11}, 1'b0);
        applyStimulus("ADDI", 6'h08, '{0, 1, 9, 10}, 1'b0);
        applyStimulus("ILL3F", 6'h3F, '{0, 1}, 1'b1);
        applyStimulus("ILL05", 6'h05, '{0, 1}, 1'b1);

        // Reset asserted in the middle of an EXECUTE cycle
        op = 6'h00;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre-reset EXECUTE", 32'(state), 32'd6);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset state", 32'(state), 32'd0);
        checkOutput("async reset reg_write", 32'(reg_write), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("held reset state", 32'(state), 32'd0);
        checkOutput("held reset reg_write", 32'(reg_write), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("R after reset", 6'h00, '{0, 1, 6, 7}, 1'b0);

`ifdef MAIN_CTRL_MEM_WAIT_EN
        begin
            int writeCycles;
            writeCycles = 0;
            op = 6'h2B;
            mem_ready = 1'b0;
            checkOutput("FETCH stall pc_write", 32'(pc_write), 32'd0);
            checkOutput("FETCH stall ir_write", 32'(ir_write), 32'd0);
            checkOutput("FETCH stall mem_read", 32'(mem_read), 32'd1);
            @(negedge clk);
            checkOutput("FETCH held", 32'(state), 32'd0);
            mem_ready = 1'b1;
            checkOutput("FETCH ready pc_write", 32'(pc_write), 32'd1);
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            checkOutput("SW wait MEMWR", 32'(state), 32'd5);
            for (int i = 0; i < 4; i++) begin
                mem_ready = (i == 3);
                #1;
                if (mem_write) writeCycles++;
                checkOutput($sformatf("SW wait state c%0d", i), 32'(state), 32'd5);
                checkOutput($sformatf("SW wait done c%0d", i), 32'(instr_done), 32'(i == 3));
                @(negedge clk);
            end
            checkOutput("SW wait mem_write cycles", 32'(writeCycles), 32'd4);
            checkOutput("SW wait back to FETCH", 32'(state), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
